// File: rtl/regfile_fib_seq_if.sv
// regfile_fib_seq_if: control and regfile bus between top, the fib sequencer and the regfile.
interface regfile_fib_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] init_a;
    logic [DATA_W-1:0] init_b;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] num;

    modport master (
        input  start, init_a, init_b, rd1, rd2,
        output ra1, ra2, we, wa, wd, busy, done, num
    );

    modport slave (
        output start, init_a, init_b, rd1, rd2,
        input  ra1, ra2, we, wa, wd, busy, done, num
    );
endinterface

// File: rtl/regfile_fib_seq.sv
// regfile_fib_seq: seeds r0/r1 then fills the regfile with r[i] = r[i-2] + r[i-1].
// Optional macro REGFILE_FIB_SAT_EN makes the add saturate to all-ones instead of wrapping.
module regfile_fib_seq #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_fib_seq_if.master    bus
);
    typedef enum logic [2:0] {IDLE, SEED0, SEED1, CALC, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state, nxt;
    logic [DATA_W-1:0] seed_a, seed_b, sum, num_q;
    logic [ADDR_W-1:0] idx, ra1_q, ra2_q;
    logic [DATA_W:0]   full;
    logic [DATA_W-1:0] add_res;

    assign full = {1'b0, bus.rd1} + {1'b0, bus.rd2};
`ifdef REGFILE_FIB_SAT_EN
    assign add_res = full[DATA_W] ? {DATA_W{1'b1}} : full[DATA_W-1:0];
`else
    assign add_res = full[DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? SEED0 : IDLE;
            SEED0:   nxt = SEED1;
            SEED1:   nxt = CALC;
            CALC:    nxt = WRITE;
            WRITE:   nxt = (idx == LAST) ? DONE : CALC;
            default: nxt = IDLE;
        endcase
    end

    // ra1/ra2 only move on the edge into CALC so they hold their value elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_a <= '0;
            seed_b <= '0;
            sum    <= '0;
            num_q  <= '0;
            idx    <= '0;
            ra1_q  <= '0;
            ra2_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    seed_a <= bus.init_a;
                    seed_b <= bus.init_b;
                end
                SEED0: num_q <= seed_a;
                SEED1: begin
                    num_q <= seed_b;
                    idx   <= ADDR_W'(2);
                    ra1_q <= '0;
                    ra2_q <= ADDR_W'(1);
                end
                CALC: sum <= add_res;
                WRITE: begin
                    num_q <= sum;
                    if (idx != LAST) begin
                        idx   <= idx + ADDR_W'(1);
                        ra1_q <= idx - ADDR_W'(1);
                        ra2_q <= idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.we   = (state == SEED0) || (state == SEED1) || (state == WRITE);
        bus.wa   = (state == SEED1) ? ADDR_W'(1) : (state == WRITE) ? idx : '0;
        bus.wd   = (state == SEED0) ? seed_a : (state == SEED1) ? seed_b :
                   (state == WRITE) ? sum : '0;
        bus.busy = (state != IDLE) && (state != DONE);
        bus.done = (state == DONE);
        bus.ra1  = ra1_q;
        bus.ra2  = ra2_q;
        bus.num  = num_q;
    end
endmodule

// File: tb/tb_regfile_fib_seq.sv
// tb_regfile_fib_seq: scoreboard bench with a behavioural regfile and Fibonacci reference model.
module tb_regfile_fib_seq;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int errors = 0;
    int wcnt = 0;
    wr_t q[$];
    logic [31:0] v[32];
    logic [31:0] mem[32];
    logic pend = 0;
    logic [31:0] pend_val = 0;

    regfile_fib_seq_if #(.DATA_W(32), .ADDR_W(5)) bus();

    regfile_fib_seq #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // behavioural regfile: async read, sync write
    always @(posedge clk) if (bus.we) mem[bus.wa] <= bus.wd;
    assign bus.rd1 = mem[bus.ra1];
    assign bus.rd2 = mem[bus.ra2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference: Fibonacci over 32-bit words, wrapping or saturating
    function automatic void model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        v[0] = a;
        v[1] = b;
        for (int i = 2; i < 32; i++) begin
            t = {1'b0, v[i-2]} + {1'b0, v[i-1]};
`ifdef REGFILE_FIB_SAT_EN
            v[i] = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
            v[i] = t[31:0];
`endif
        end
        for (int i = 0; i < 32; i++) q.push_back('{addr: 5'(i), data: v[i]});
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) chk("num", bus.num, pend_val);
            pend = 0;
            if (bus.we) begin
                wcnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write wa=%0d wd=%0h", bus.wa, bus.wd);
                end else begin
                    e = q.pop_front();
                    chk("wa", 32'(bus.wa), 32'(e.addr));
                    chk("wd", bus.wd, e.data);
                    pend = 1;
                    pend_val = e.data;
                end
            end else if (bus.busy && q.size() > 0) begin
                chk("ra1", 32'(bus.ra1), 32'(5'(q[0].addr - 5'd2)));
                chk("ra2", 32'(bus.ra2), 32'(5'(q[0].addr - 5'd1)));
            end
        end
    end

    // glitch: 0 none, 10 re-pulse start at cycle 10, 20 reset at cycle 20
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int glitch);
        int n;
        model(a, b);
        wcnt = 0;
        bus.init_a = a;
        bus.init_b = b;
        bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n < 63) chk("busy_run", 32'(bus.busy), 1);
            if (glitch == 10 && n == 10) begin
                bus.init_a = 32'hDEAD_BEEF;
                bus.init_b = 32'h1234_5678;
                bus.start = 1;
            end
            if (glitch == 10 && n == 11) bus.start = 0;
            if (glitch == 20 && n == 20) begin
                #2 rst_n = 0;
                #1 chk("rst_we", 32'(bus.we), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                q.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                @(negedge clk);
                chk("rst_idle", 32'(bus.busy), 0);
                return;
            end
        end while (!bus.done && n < 200);
        chk("done_latency", 32'(n), 63);
        chk("we_cycles", 32'(wcnt), 32);
        chk("queue_empty", 32'(q.size()), 0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1;
        bus.init_a = 32'h5;
        bus.init_b = 32'h7;
        for (int i = 0; i < 32; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_wa", 32'(bus.wa), 0);
        chk("rst_wd", bus.wd, 0);
        chk("rst_ra1", 32'(bus.ra1), 0);
        chk("rst_ra2", 32'(bus.ra2), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_num", bus.num, 0);
        bus.start = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_we", 32'(bus.we), 0);

        run(32'd1, 32'd1, 0);
        chk("fib_r31", mem[31], 32'd2178309);
        chk("fib_r5", mem[5], 32'd8);

        run(32'hFFFF_FFF0, 32'h20, 0);
`ifdef REGFILE_FIB_SAT_EN
        chk("r2_edge", mem[2], 32'hFFFF_FFFF);
        chk("r31_edge", mem[31], 32'hFFFF_FFFF);
`else
        chk("r2_edge", mem[2], 32'h10);
`endif

        run(32'd3, 32'd4, 10);
        chk("restart_r0", mem[0], 32'd3);
        chk("restart_r31", mem[31], v[31]);

        run(32'd7, 32'd9, 20);
        chk("kept_r0", mem[0], 32'd7);
        chk("kept_r1", mem[1], 32'd9);
        run(32'd2, 32'd3, 0);
        chk("fresh_r2", mem[2], 32'd5);
        chk("fresh_r31", mem[31], v[31]);

        for (int k = 0; k < 3; k++) begin
            run($urandom, $urandom, 0);
            chk("rand_r31", mem[31], v[31]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
